compare: RTL and testbench

RV32I branch-condition comparator for the execute stage.
- Evaluates the branch condition selected by funct3 on two 32-bit operands.
- Drives a combinational taken flag for same-cycle PC selection.
- Also provides a registered copy of the result, a valid strobe, illegal-encoding detection and a saturating taken counter for debug/perf.

---
 rtl/compare_pkg.sv | 20 ++
 rtl/compare_core.sv | 38 +++
 rtl/compare.sv | 77 +++++++
 tb/tb_compare.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// compare_pkg: shared types and helpers for the RV32I branch comparator.
//   br_f3_e       - funct3 encodings of the six conditional branches
//   is_branch_f3  - 1 when a funct3 value names a real branch condition
package compare_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd4,
    BGE  = 3'd5,
    BLTU = 3'd6,
    BGEU = 3'd7
  } br_f3_e;

  // 3'h2 and 3'h3 are the only unused encodings in the branch opcode space.
  function automatic logic is_branch_f3(input logic [2:0] f3);
    return (f3 != 3'd2) && (f3 != 3'd3);
  endfunction

endpackage

// File: rtl/compare_core.sv
// compare_core: purely combinational branch-condition evaluation.
//   A, B     in  WIDTH  operands (rs1, rs2)
//   funct3   in  3      condition select
//   flag     out 1      condition result (0 on illegal encodings)
//   illegal  out 1      funct3 is not a branch condition
module compare_core
  import compare_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       funct3,
  output logic             flag,
  output logic             illegal
);

  logic w_eq, w_lt_s, w_lt_u;

  assign w_eq   = (A == B);
  assign w_lt_s = ($signed(A) < $signed(B));
  assign w_lt_u = (A < B);

  always_comb begin
    flag    = 1'b0;
    illegal = !is_branch_f3(funct3);
    case (funct3)
      BEQ:     flag = w_eq;
      BNE:     flag = !w_eq;
      BLT:     flag = w_lt_s;
      BGE:     flag = !w_lt_s;
      BLTU:    flag = w_lt_u;
      BGEU:    flag = !w_lt_u;
      default: flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/compare.sv
// compare: execute-stage branch comparator with debug/perf registers.
//   clk, reset  in   clock, synchronous active-high reset
//   A, B        in   WIDTH operands
//   funct3      in   condition select
//   in_valid    in   qualifies the inputs for the registered path and counter
//   flag        out  combinational taken flag (for same-cycle PC select)
//   illegal     out  combinational illegal-encoding flag
//   flag_q      out  flag captured on in_valid
//   out_valid   out  in_valid delayed one cycle
//   illegal_q   out  illegal captured on in_valid
//   taken_cnt   out  saturating count of accepted taken evaluations
module compare
  import compare_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           funct3,
  input  logic                 in_valid,
  output logic                 flag,
  output logic                 illegal,
  output logic                 flag_q,
  output logic                 out_valid,
  output logic                 illegal_q,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  localparam int STAGES = 1;

  logic                 w_flag, w_illegal, w_take;
  logic [STAGES:0]      r_vld_pipe;
  logic                 r_flag_q, r_illegal_q;
  logic [CNT_WIDTH-1:0] r_cnt;

  compare_core #(.WIDTH(WIDTH)) u_core (
    .A      (A),
    .B      (B),
    .funct3 (funct3),
    .flag   (w_flag),
    .illegal(w_illegal)
  );

  // Slot 0 is the live input; only the registered slots carry state.
  always_comb r_vld_pipe[0] = in_valid;

  assign w_take = in_valid && w_flag && !w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe[STAGES:1] <= '0;
      r_flag_q             <= 1'b0;
      r_illegal_q          <= 1'b0;
      r_cnt                <= '0;
    end else begin
      r_vld_pipe[STAGES:1] <= r_vld_pipe[STAGES-1:0];
      if (in_valid) begin
        r_flag_q    <= w_flag;
        r_illegal_q <= w_illegal;
      end
      // Saturate rather than wrap so a long run never reads back as small.
      if (w_take && (r_cnt != {CNT_WIDTH{1'b1}}))
        r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign flag      = w_flag;
  assign illegal   = w_illegal;
  assign flag_q    = r_flag_q;
  assign illegal_q = r_illegal_q;
  assign out_valid = r_vld_pipe[STAGES];
  assign taken_cnt = r_cnt;

endmodule

// File: tb/tb_compare.sv
module tb_compare;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  funct3 = '0;
  logic        in_valid = 1'b0;

  logic        flag, illegal, flag_q, out_valid, illegal_q;
  logic [31:0] taken_cnt;
  logic        s_flag, s_illegal, s_flag_q, s_out_valid, s_illegal_q;
  logic [2:0]  s_taken_cnt;

  int tests = 0;
  int fails = 0;

  // Reference state
  bit          m_valid, m_flag_q, m_ill_q;
  longint      m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  compare #(.WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .funct3(funct3), .in_valid(in_valid),
    .flag(flag), .illegal(illegal), .flag_q(flag_q), .out_valid(out_valid),
    .illegal_q(illegal_q), .taken_cnt(taken_cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  compare #(.WIDTH(32), .CNT_WIDTH(3)) dut_s (
    .clk(clk), .reset(reset), .A(A), .B(B), .funct3(funct3), .in_valid(in_valid),
    .flag(s_flag), .illegal(s_illegal), .flag_q(s_flag_q), .out_valid(s_out_valid),
    .illegal_q(s_illegal_q), .taken_cnt(s_taken_cnt)
  );

  function automatic longint as_signed(input logic [31:0] v);
    longint u = longint'(v);
    return (u >= 64'sd2147483648) ? u - 64'sd4294967296 : u;
  endfunction

  function automatic bit ref_illegal(input logic [2:0] f3);
    return (f3 == 3'd2) || (f3 == 3'd3);
  endfunction

  function automatic bit ref_flag(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    longint sa = as_signed(a), sb = as_signed(b);
    longint ua = longint'(a), ub = longint'(b);
    case (f3)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check combinational outputs, clock, check registers.
  task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input bit v, input bit rst);
    bit ef, ei;
    A = a; B = b; funct3 = f3; in_valid = v; reset = rst;
    ef = ref_flag(a, b, f3);
    ei = ref_illegal(f3);
    #1;
    check("flag", flag, ef);
    check("illegal", illegal, ei);
    check("s_flag", s_flag, ef);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_flag_q = 0; m_ill_q = 0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_flag_q = ef;
        m_ill_q  = ei;
        if (ef && !ei) begin
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          if (m_cnt_s < 7) m_cnt_s++;
        end
      end
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("flag_q", flag_q, m_flag_q);
    check("illegal_q", illegal_q, m_ill_q);
    check("taken_cnt", taken_cnt, m_cnt);
    check("s_out_valid", s_out_valid, m_valid);
    check("s_taken_cnt", s_taken_cnt, m_cnt_s);
    @(negedge clk);
  endtask

  // Directed combinational vector with a hard-coded expected flag.
  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] f3, input bit exp_flag);
    A = a; B = b; funct3 = f3; in_valid = 1'b0;
    #1;
    check(tag, flag, exp_flag);
  endtask

  initial begin
    logic [31:0] edges [6];
    logic [31:0] ra, rb;
    edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF; edges[5] = 32'h5;

    // Reset, with combinational path live during reset
    @(negedge clk);
    cycle(32'd5, 32'd5, 3'd0, 1'b1, 1'b1);
    cycle(32'd5, 32'd5, 3'd0, 1'b0, 1'b1);

    dir("beq_eq",    32'd5, 32'd5, 3'd0, 1'b1);
    dir("bne_eq",    32'd5, 32'd5, 3'd1, 1'b0);
    dir("bne_ne",    32'd5, 32'd3, 3'd1, 1'b1);
    dir("blt",       32'd5, 32'd10, 3'd4, 1'b1);
    dir("bge",       32'd10, 32'd5, 3'd5, 1'b1);
    dir("bltu",      32'd5, 32'd10, 3'd6, 1'b1);
    dir("bgeu",      32'd10, 32'd5, 3'd7, 1'b1);
    dir("blt_neg1",  32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1);
    dir("bltu_max",  32'hFFFF_FFFF, 32'd1, 3'd6, 1'b0);
    dir("blt_min",   32'h8000_0000, 32'd0, 3'd4, 1'b1);
    dir("bltu_min",  32'h8000_0000, 32'd0, 3'd6, 1'b0);
    dir("blt_eq",    32'd7, 32'd7, 3'd4, 1'b0);
    dir("bge_eq",    32'd7, 32'd7, 3'd5, 1'b1);
    dir("bltu_eq",   32'd7, 32'd7, 3'd6, 1'b0);
    dir("bgeu_eq",   32'd7, 32'd7, 3'd7, 1'b1);
    dir("f3_2_flag", 32'd1, 32'd1, 3'd2, 1'b0);
    A = 32'd1; B = 32'd9; funct3 = 3'd3; #1;
    check("f3_3_illegal", illegal, 1'b1);
    funct3 = 3'd4; #1;
    check("f3_4_legal", illegal, 1'b0);
    @(negedge clk);

    // Registered path: three taken evaluations, then idle (flag_q holds)
    cycle(32'd5, 32'd5, 3'd0, 1'b1, 1'b0);
    cycle(32'd1, 32'd2, 3'd4, 1'b1, 1'b0);
    cycle(32'd9, 32'd2, 3'd7, 1'b1, 1'b0);
    cycle(32'd9, 32'd9, 3'd1, 1'b0, 1'b0);
    cycle(32'd9, 32'd9, 3'd1, 1'b0, 1'b0);
    check("cnt_three", taken_cnt, 64'd3);

    // Illegal encoding accepted: illegal_q set, counter unchanged
    cycle(32'd3, 32'd3, 3'd2, 1'b1, 1'b0);
    cycle(32'd3, 32'd4, 3'd3, 1'b1, 1'b0);
    check("cnt_after_illegal", taken_cnt, 64'd3);

    // Reset wins over a simultaneous in_valid
    cycle(32'd5, 32'd5, 3'd0, 1'b1, 1'b1);
    check("rst_cnt", taken_cnt, 64'd0);

    // Drive the narrow counter into saturation
    for (int i = 0; i < 10; i++) cycle(32'd4, 32'd4, 3'd5, 1'b1, 1'b0);
    check("sat_cnt", s_taken_cnt, 64'd7);

    // Randomized traffic with biased operands
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = edges[$urandom_range(0, 5)];
        default: rb = $urandom;
      endcase
      cycle(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
